gray_count_checker: RTL and testbench
=====================================

// Module: gray_count_checker
// PURPOSE
//  Receive end of a Gray_count bus: resynchronises a WIDTH-bit Gray code from another
//  clock domain, decodes it to binary and checks each accepted sample for a legal step.
//  Sits after a Gray counter crossing a clock boundary (e.g. FIFO pointers, position counters).
//  Reports the decoded count, step/wrap events, and illegal-transition errors with a sticky flag
//  and a saturating error counter.
// PARAMETERS
//  WIDTH        5   Gray/binary count width, >=2
//  SYNC_STAGES  2   synchroniser flops on gray_in; 0 = bypass (same-domain source)
//  ERR_W        4   err_count width
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        asynchronous, active-low reset
//  enable      in   1        accept the synchronised sample this cycle (local domain, not synchronised)
//  gray_in     in   WIDTH    Gray-coded count from the source counter
//  clear_err   in   1        clears err_sticky and err_count
//  bin_count   out  WIDTH    binary value of the last accepted sample
//  valid       out  1        high while state == TRACK
//  step        out  1        1-cycle pulse: accepted sample = previous + 1 (mod 2^WIDTH)
//  wrap        out  1        1-cycle pulse: step from all-ones to 0 (coincides with step)
//  err         out  1        1-cycle pulse: illegal transition detected
//  err_sticky  out  1        set by err, held until clear_err
//  err_count   out  ERR_W    number of err pulses, saturating at 2^ERR_W-1
// BEHAVIOUR
//  - Reset (reset=0, async): synchroniser flops, bin_count, err_count = 0; valid, step, wrap,
//    err, err_sticky = 0; state = ACQUIRE. Reset assertion takes effect immediately, mid-stream included.
//  - Pipeline: gray_in -> SYNC_STAGES flops -> g_s. Decode dec = g_s ^ (g_s>>1) ^ (g_s>>2) ... (prefix XOR from MSB).
//  - All outputs are registered. Latency from gray_in to outputs is SYNC_STAGES+1 rising edges.
//  - A sample is accepted on an edge where enable=1. enable=0: no state, bin_count, or pulse change.
//  - delta = dec - bin_count, modulo 2^WIDTH.
//  - State ACQUIRE: an accepted sample loads bin_count=dec and moves to TRACK; no step/err.
//  - State TRACK:
//      delta==0: no event.
//      delta==1: bin_count=dec, step=1; wrap=1 if old bin_count was all-ones.
//      otherwise: bin_count=dec, err=1, move to FAULT.
//  - State FAULT:
//      delta==0: no event.
//      delta==1: bin_count=dec, step (and wrap) as in TRACK, move to TRACK.
//      otherwise: bin_count=dec, err=1, stay in FAULT.
//  - Pulses (step, wrap, err) are high for exactly one cycle per accepted sample.
//  - err_sticky: err and clear_err on the same edge -> set wins (err_sticky=1).
//  - err_count: err and clear_err on the same edge -> err_count=1. Otherwise
//    clear_err -> 0 and err -> +1, held at max.
//  - State encoding has 3 states; an unused encoding returns to ACQUIRE.
// TESTING (WIDTH=5, SYNC_STAGES=2, ERR_W=4)
//  1. Reset low then high; enable=1; gray_in 00000,00001,00011,00010, one per cycle
//     -> 3 edges after the first value: valid=1, bin_count 0,1,2,3; three step pulses; no err.
//  2. Track up to gray 10000 (bin 31), then 00000
//     -> bin_count 0 with step=1 and wrap=1 in the same cycle.
//  3. From gray 00010 (bin 3), apply 00111 (bin 5)
//     -> err=1, err_sticky=1, err_count=1, valid=0.
//     Then 00101 (bin 6) -> step=1, valid=1, err_sticky stays 1.
//  4. enable=0 while gray_in changes, and repeated identical samples with enable=1
//     -> bin_count constant; no step/wrap/err.
//  5. 20 consecutive illegal jumps -> err_count saturates at 15.
//     Then clear_err together with an err -> err_count=1, err_sticky=1.
//     Then clear_err alone -> both 0.
//  6. Drop reset mid-stream, asynchronously between edges -> all outputs 0 immediately.
//     After release, the first accepted sample re-acquires: valid=1 with no step.

Source files
------------

// File: rtl/gray_count_checker.sv
// Receive side of a Gray-coded count crossing: resynchronises the code,
// decodes it to binary and flags any sample that is not a +1 step.
module gray_count_checker #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clear_err,
  output logic [WIDTH-1:0] bin_count,
  output logic             valid,
  output logic             step,
  output logic             wrap,
  output logic             err,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] delta;
  logic             is_step, is_same;

  logic [WIDTH-1:0] bin_nxt;
  logic             valid_nxt, step_nxt, wrap_nxt, err_nxt, sticky_nxt;
  logic [ERR_W-1:0] count_nxt;

  // Synchroniser chain; zero stages means the source shares our clock.
  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign g_s = gray_in;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];

      // Shift the Gray code through the synchroniser flops.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= gray_in;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign g_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    dec            = '0;
    dec[WIDTH-1]   = g_s[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) dec[i] = dec[i+1] ^ g_s[i];
  end

  assign delta   = WIDTH'(dec - bin_count);
  assign is_step = (delta == WIDTH'(1));
  assign is_same = (delta == '0);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ACQUIRE;
    else        state <= state_nxt;
  end

  // Next-state logic; the unused encoding falls back to ACQUIRE.
  always_comb begin
    state_nxt = state;
    case (state)
      ACQUIRE: if (enable) state_nxt = TRACK;
      TRACK:   if (enable && !is_same && !is_step) state_nxt = FAULT;
      FAULT:   if (enable && is_step) state_nxt = TRACK;
      default: state_nxt = ACQUIRE;
    endcase
  end

  // Next values for the registered outputs.
  always_comb begin
    bin_nxt  = bin_count;
    step_nxt = 1'b0;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (enable) begin
      case (state)
        ACQUIRE: bin_nxt = dec;
        TRACK, FAULT: begin
          if (is_step) begin
            bin_nxt  = dec;
            step_nxt = 1'b1;
            wrap_nxt = &bin_count;
          end else if (!is_same) begin
            bin_nxt = dec;
            err_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end

    valid_nxt = (state_nxt == TRACK);

    // A new error outranks a clear on the same edge.
    sticky_nxt = err_nxt ? 1'b1 : (clear_err ? 1'b0 : err_sticky);

    count_nxt = err_count;
    if (err_nxt && clear_err)                  count_nxt = ERR_W'(1);
    else if (clear_err)                        count_nxt = '0;
    else if (err_nxt && err_count != ERR_MAX)  count_nxt = ERR_W'(err_count + ERR_W'(1));
  end

  // Output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_count  <= '0;
      valid      <= 1'b0;
      step       <= 1'b0;
      wrap       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      bin_count  <= bin_nxt;
      valid      <= valid_nxt;
      step       <= step_nxt;
      wrap       <= wrap_nxt;
      err        <= err_nxt;
      err_sticky <= sticky_nxt;
      err_count  <= count_nxt;
    end
  end

endmodule

// File: tb/tb_gray_count_checker.sv
// Bench for gray_count_checker: directed scenarios followed by a random walk,
// every cycle compared against a table-driven reference model.
module tb_gray_count_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [4:0] gray_in;
  logic       clear_err;
  logic [4:0] bin_count;
  logic       valid, step, wrap, err, err_sticky;
  logic [3:0] err_count;

  gray_count_checker #(.WIDTH(5), .SYNC_STAGES(2), .ERR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .gray_in    (gray_in),
    .clear_err  (clear_err),
    .bin_count  (bin_count),
    .valid      (valid),
    .step       (step),
    .wrap       (wrap),
    .err        (err),
    .err_sticky (err_sticky),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;

  // Reference model state.
  int g2b [32];
  int pipe [$];
  int m_bin, m_acq, m_ok, m_step, m_wrap, m_err, m_sticky, m_cnt;
  int cur;

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & 31;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("bin_count",  int'(bin_count),  m_bin);
    chk("valid",      int'(valid),      (m_acq != 0 && m_ok != 0) ? 1 : 0);
    chk("step",       int'(step),       m_step);
    chk("wrap",       int'(wrap),       m_wrap);
    chk("err",        int'(err),        m_err);
    chk("err_sticky", int'(err_sticky), m_sticky);
    chk("err_count",  int'(err_count),  m_cnt);
  endtask

  task automatic model_reset();
    pipe.delete();
    pipe.push_back(0);
    pipe.push_back(0);
    m_bin = 0; m_acq = 0; m_ok = 0; m_step = 0; m_wrap = 0;
    m_err = 0; m_sticky = 0; m_cnt = 0;
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cyc(input logic en, input int g, input logic clr);
    int gs, d, delta;
    enable    = en;
    gray_in   = 5'(g);
    clear_err = clr;
    @(posedge clk);
    #1;
    pipe.push_back(g & 31);
    gs = pipe.pop_front();
    d  = g2b[gs];
    m_step = 0; m_wrap = 0; m_err = 0;
    if (en) begin
      if (m_acq == 0) begin
        m_bin = d; m_acq = 1; m_ok = 1;
      end else begin
        delta = (d - m_bin + 32) % 32;
        if (delta == 1) begin
          m_wrap = (m_bin == 31) ? 1 : 0;
          m_step = 1; m_bin = d; m_ok = 1;
        end else if (delta != 0) begin
          m_err = 1; m_bin = d; m_ok = 0;
        end
      end
    end
    if (m_err != 0 && clr)  m_cnt = 1;
    else if (clr)           m_cnt = 0;
    else if (m_err != 0)    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
    if (m_err != 0)   m_sticky = 1;
    else if (clr)     m_sticky = 0;
    check_all();
  endtask

  initial begin
    int r;
    for (int i = 0; i < 32; i++) g2b[(i ^ (i >> 1)) & 31] = i;
    model_reset();
    reset = 1'b0; enable = 1'b0; gray_in = '0; clear_err = 1'b0;

    // Reset state while reset is held.
    #12;
    check_all();
    reset = 1'b1;

    // Counting 0..3 then pipeline flush.
    for (int b = 0; b < 4; b++) cyc(1'b1, b2g(b), 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, b2g(3), 1'b0);

    // Up to 31 then wrap to 0.
    for (int b = 4; b < 32; b++) cyc(1'b1, b2g(b), 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 0, 1'b0);

    // Illegal jump 3 -> 5, then recovery step to 6.
    for (int b = 1; b < 4; b++) cyc(1'b1, b2g(b), 1'b0);
    cyc(1'b1, b2g(3), 1'b0);
    cyc(1'b1, b2g(3), 1'b0);
    cyc(1'b1, 5'b00111, 1'b0);
    cyc(1'b1, 5'b00101, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 5'b00101, 1'b0);

    // enable low while gray_in wanders, then repeated identical samples.
    for (int k = 0; k < 6; k++) cyc(1'b0, int'($urandom_range(0, 31)), 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, b2g(6), 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, b2g(6), 1'b0);

    // 22 illegal jumps saturate the counter; clear collides with an error.
    for (int i = 0; i < 22; i++) cyc(1'b1, b2g((8 + 2 * i) % 32), 1'b0);
    cyc(1'b1, b2g((8 + 2 * 22) % 32), 1'b1);
    cur = (8 + 2 * 22) % 32;
    for (int k = 0; k < 3; k++) cyc(1'b1, b2g(cur), 1'b0);
    cyc(1'b1, b2g(cur), 1'b1);
    cyc(1'b1, b2g(cur), 1'b0);

    // Legal steps, then asynchronous reset between edges.
    for (int k = 1; k < 5; k++) cyc(1'b1, b2g((cur + k) % 32), 1'b0);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #2;
    reset = 1'b1;
    cur = 0;
    for (int k = 0; k < 4; k++) cyc(1'b1, 0, 1'b0);

    // Random walk: mostly legal steps, some repeats, jumps, idles and clears.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)      begin cur = (cur + 1) % 32; cyc(1'b1, b2g(cur), ($urandom_range(0, 15) == 0)); end
      else if (r <= 7) cyc(1'b1, b2g(cur), ($urandom_range(0, 15) == 0));
      else if (r == 8) begin cur = int'($urandom_range(0, 31)); cyc(1'b1, b2g(cur), 1'b0); end
      else             cyc(1'b0, b2g(cur), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
